// File: rtl/iob_be_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : iob_be_mem_responder_if
//  Description : Cache back-end native bus (valid/addr/wdata/wstrb request,
//                ready accept, rvalid/rdata read return). The master is the
//                cache; the slave is the memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface iob_be_mem_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  be_valid_i;
   logic [ADDR_W-1:0]     be_addr_i;
   logic [DATA_W-1:0]     be_wdata_i;
   logic [DATA_W/8-1:0]   be_wstrb_i;
   logic                  be_ready_o;
   logic                  be_rvalid_o;
   logic [DATA_W-1:0]     be_rdata_o;

   modport master (
      output be_valid_i, be_addr_i, be_wdata_i, be_wstrb_i,
      input  be_ready_o, be_rvalid_o, be_rdata_o
   );

   modport slave (
      input  be_valid_i, be_addr_i, be_wdata_i, be_wstrb_i,
      output be_ready_o, be_rvalid_o, be_rdata_o
   );
endinterface
`default_nettype wire

// File: rtl/iob_be_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : iob_be_mem_responder
//  Description : Word-organised RAM answering the cache back-end bus.
//                One request at a time: writes commit on the accepting edge,
//                reads return a single rvalid pulse RD_LAT cycles after
//                acceptance. Every completed access may be followed by
//                STALL_CYCLES cycles of ready low to stress the master.
//  Options     : `define BE_MEM_RANGE_CHECK_EN to flag and suppress accesses
//                whose address lies above the RAM (sticky err_o, reads return
//                32'hDEADBEEF, writes dropped). Without it addresses alias.
//  Revision    : 1.0  initial release
// ============================================================================
module iob_be_mem_responder #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_ADDR_W   = 12,
   parameter int RD_LAT       = 2,
   parameter int STALL_CYCLES = 0
) (
   input  wire logic               clk,
   input  wire logic               reset_n,
   iob_be_mem_responder_if.slave   be,
   output logic                    err_o
);

   localparam int              c_NB         = DATA_W / 8;
   localparam int              c_DEPTH      = 1 << MEM_ADDR_W;
   localparam logic [3:0]      c_LAT_LOAD   = 4'(RD_LAT - 1);
   localparam logic [3:0]      c_STALL_LAST = 4'(STALL_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RESP    = 2'd2,
      S_STALL   = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [3:0]              r_lat_cnt;
   logic [3:0]              r_stall_cnt;
   logic [MEM_ADDR_W-1:0]   r_widx;
   logic [DATA_W-1:0]       r_rdata;
   logic [DATA_W-1:0]       r_mem [c_DEPTH];

   logic                    w_accept;
   logic                    w_is_wr;
   logic                    w_oor;
   logic                    w_wr_en;
   logic [MEM_ADDR_W-1:0]   w_widx;
   logic [MEM_ADDR_W-1:0]   w_rd_idx;
   logic [DATA_W-1:0]       w_rd_word;
   logic                    w_unused_addr;

   // Request decode; a request is only ever taken while idle.
   assign w_accept = be.be_valid_i && (r_state == S_IDLE);
   assign w_is_wr  = |be.be_wstrb_i;
   assign w_widx   = be.be_addr_i[MEM_ADDR_W+1:2];

   // Byte-offset bits are never used; upper bits only feed the range check.
   assign w_unused_addr = ^{be.be_addr_i[1:0], be.be_addr_i[ADDR_W-1:MEM_ADDR_W+2]};

   // The word being read comes from the live address when RD_LAT==1
   // (read goes straight from IDLE to RESP), otherwise from the latched one.
   assign w_rd_idx = (r_state == S_IDLE) ? w_widx : r_widx;

`ifdef BE_MEM_RANGE_CHECK_EN
   logic r_oor;
   logic r_err;
   logic w_rd_oor;

   assign w_oor     = |be.be_addr_i[ADDR_W-1:MEM_ADDR_W+2];
   assign w_rd_oor  = (r_state == S_IDLE) ? w_oor : r_oor;
   assign w_rd_word = w_rd_oor ? DATA_W'(32'hDEADBEEF) : r_mem[w_rd_idx];
   assign err_o     = r_err;

   // Out-of-range tracking: per-read flag for the response, sticky error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_oor <= 1'b0;
         r_err <= 1'b0;
      end else if (w_accept) begin
         if (!w_is_wr) begin
            r_oor <= w_oor;
         end
         if (w_oor) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   assign w_oor     = 1'b0;
   assign w_rd_word = r_mem[w_rd_idx];
   assign err_o     = 1'b0;
`endif

   // Reset gates the write so nothing commits while the block is held in reset.
   assign w_wr_en = reset_n && w_accept && w_is_wr && !w_oor;

   // RAM write port: byte-masked commit on the accepting edge.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < c_NB; b++) begin
            if (be.be_wstrb_i[b]) begin
               r_mem[w_widx][8*b +: 8] <= be.be_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_is_wr) begin
                  w_state_nxt = (STALL_CYCLES > 0) ? S_STALL : S_IDLE;
               end else begin
                  w_state_nxt = (RD_LAT == 1) ? S_RESP : S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (r_lat_cnt == 4'd1) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = (STALL_CYCLES > 0) ? S_STALL : S_IDLE;
         end
         S_STALL: begin
            if (r_stall_cnt == c_STALL_LAST) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state only; rdata register is already
   // zero outside the response cycle.
   always_comb begin
      be.be_ready_o  = 1'b0;
      be.be_rvalid_o = 1'b0;
      be.be_rdata_o  = r_rdata;
      if (r_state == S_IDLE) begin
         be.be_ready_o = 1'b1;
      end
      if (r_state == S_RESP) begin
         be.be_rvalid_o = 1'b1;
      end
   end

   // Read latency counter and latched word index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lat_cnt <= 4'd0;
         r_widx    <= '0;
      end else if (w_accept && !w_is_wr) begin
         r_lat_cnt <= c_LAT_LOAD;
         r_widx    <= w_widx;
      end else if (r_state == S_RD_WAIT) begin
         r_lat_cnt <= r_lat_cnt - 4'd1;
      end
   end

   // Post-access throttle counter; restarts from zero on every STALL entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= 4'd0;
      end else if ((r_state == S_STALL) && (w_state_nxt == S_STALL)) begin
         r_stall_cnt <= r_stall_cnt + 4'd1;
      end else begin
         r_stall_cnt <= 4'd0;
      end
   end

   // Read data register: loaded on the edge entering RESP, cleared otherwise.
   // No write can land between acceptance and this load (ready is low).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata <= '0;
      end else if (w_state_nxt == S_RESP) begin
         r_rdata <= w_rd_word;
      end else begin
         r_rdata <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iob_be_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_be_mem_responder
//  Description : Bench for iob_be_mem_responder. Four responders with
//                different latency/throttle settings share one request
//                driver; only the selected one sees be_valid_i. A cycle-level
//                model predicts ready/rvalid/rdata/err for every instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iob_be_mem_responder;

   localparam int N = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        tb_valid = 1'b0;
   logic [31:0] tb_addr  = 32'h0;
   logic [31:0] tb_wdata = 32'h0;
   logic [3:0]  tb_wstrb = 4'h0;
   int          sel = 0;
   logic        chk_en = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [N-1:0] d_ready;
   logic [N-1:0] d_rvalid;
   logic [N-1:0] d_err;
   logic [31:0]  d_rdata [N];

   always #5 clk = ~clk;

   function automatic int lat_of(input int s);
      case (s)
         0:       return 2;
         1:       return 4;
         2:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int stall_of(input int s);
      return (s == 1) ? 3 : 0;
   endfunction

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         iob_be_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();
         assign bus.be_valid_i = tb_valid && (sel == g);
         assign bus.be_addr_i  = tb_addr;
         assign bus.be_wdata_i = tb_wdata;
         assign bus.be_wstrb_i = tb_wstrb;
         assign d_ready[g]     = bus.be_ready_o;
         assign d_rvalid[g]    = bus.be_rvalid_o;
         assign d_rdata[g]     = bus.be_rdata_o;
         iob_be_mem_responder #(
            .ADDR_W       (32),
            .DATA_W       (32),
            .MEM_ADDR_W   (12),
            .RD_LAT       ((g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 8),
            .STALL_CYCLES ((g == 1) ? 3 : 0)
         ) u_dut (
            .clk     (clk),
            .reset_n (rst_n),
            .be      (bus.slave),
            .err_o   (d_err[g])
         );
      end
   endgenerate

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, g, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   // cyc = number of rising edges since start (frozen in reset). An access
   // accepted on edge k keeps the responder busy until cycle m_busy; a read
   // returns in cycle k+RD_LAT-1.
   int          cyc    = 0;
   int          m_busy = 0;
   int          m_resp = -1;
   logic [31:0] m_data = 32'h0;
   logic [31:0] m_mem [int];
   logic [N-1:0] m_err = '0;

   always @(posedge clk or negedge rst_n) begin
      int prev;
      int key;
      logic oor;
      logic [31:0] w;
      if (!rst_n) begin
         m_busy = cyc;
         m_resp = -1;
         m_err  = '0;
      end else begin
         prev = cyc;
         cyc  = cyc + 1;
         if (tb_valid && (prev >= m_busy)) begin
            key = sel * 4096 + int'(tb_addr[13:2]);
`ifdef BE_MEM_RANGE_CHECK_EN
            oor = (tb_addr[31:14] != 18'h0);
            if (oor) m_err[sel] = 1'b1;
`else
            oor = 1'b0;
`endif
            if (tb_wstrb != 4'h0) begin
               if (!oor) begin
                  w = m_mem.exists(key) ? m_mem[key] : 32'h0;
                  for (int b = 0; b < 4; b++)
                     if (tb_wstrb[b]) w[8*b +: 8] = tb_wdata[8*b +: 8];
                  m_mem[key] = w;
               end
               m_busy = cyc + stall_of(sel);
            end else begin
               m_data = oor ? 32'hDEADBEEF : (m_mem.exists(key) ? m_mem[key] : 32'h0);
               m_resp = cyc + lat_of(sel) - 1;
               m_busy = cyc + lat_of(sel) + stall_of(sel);
            end
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin
      logic        er;
      logic        ev;
      logic [31:0] ed;
      if (chk_en) begin
         for (int g = 0; g < N; g++) begin
            if (g == sel) begin
               er = (cyc >= m_busy);
               ev = (cyc == m_resp);
               ed = ev ? m_data : 32'h0;
            end else begin
               er = 1'b1;
               ev = 1'b0;
               ed = 32'h0;
            end
            chk("ready",  g, {31'h0, d_ready[g]},  {31'h0, er});
            chk("rvalid", g, {31'h0, d_rvalid[g]}, {31'h0, ev});
            chk("rdata",  g, d_rdata[g], ed);
            chk("err",    g, {31'h0, d_err[g]},    {31'h0, m_err[g]});
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc);
      int   n   = 0;
      logic got = 1'b0;
      tb_valid = 1'b1;
      tb_addr  = a;
      tb_wdata = d;
      tb_wstrb = s;
      while (!got && n < 50) begin
         @(negedge clk);
         got = d_ready[sel];
         @(posedge clk);
         #1;
         n++;
      end
      tb_valid = 1'b0;
      tb_wstrb = 4'h0;
      acc = cyc;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL accept_timeout[%0d]: got no ready, expected ready within 50 cycles", sel);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int k;
      drive_req(a, d, s, k);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data, output int lat);
      int   k;
      int   n    = 0;
      logic seen = 1'b0;
      data = 32'h0;
      lat  = 0;
      drive_req(a, 32'h0, 4'h0, k);
      while (!seen && n < 40) begin
         @(negedge clk);
         if (d_rvalid[sel]) begin
            seen = 1'b1;
            data = d_rdata[sel];
            lat  = cyc - k + 1;
         end
         n++;
      end
      @(posedge clk);
      #1;
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL rvalid_timeout[%0d]: got no rvalid, expected one within 40 cycles", sel);
      end
   endtask

   task automatic count_ready_low(output int cnt);
      int n = 0;
      cnt = 0;
      @(negedge clk);
      while (!d_ready[sel] && n < 20) begin
         cnt++;
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (cyc < m_busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic select(input int s);
      wait_idle();
      sel = s;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [31:0] rd;
      int          lat;
      int          cnt;
      int          acc [4];

      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset while idle.
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_ready",  0, {31'h0, d_ready[0]},  32'h1);
      chk("rst_rvalid", 0, {31'h0, d_rvalid[0]}, 32'h0);
      chk("rst_rdata",  0, d_rdata[0], 32'h0);
      chk("rst_err",    0, {31'h0, d_err[0]},    32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write then read, RD_LAT=2.
      select(0);
      do_write(32'h40, 32'h12345678, 4'hF);
      do_read(32'h40, rd, lat);
      chk("t2_rdata", 0, rd, 32'h12345678);
      chk("t2_lat",   0, lat, 32'd2);

      // Byte strobes.
      do_write(32'h80, 32'hAABBCCDD, 4'hF);
      do_write(32'h80, 32'h11223344, 4'b0101);
      do_read(32'h80, rd, lat);
      chk("t3_rdata", 0, rd, 32'hAA22CC44);

      // Back-to-back writes on consecutive edges.
      for (int i = 0; i < 4; i++) begin
         tb_valid = 1'b0;
         drive_req(32'(4 * i), 32'h0A0B0C00 + 32'(i), 4'hF, acc[i]);
      end
      for (int i = 1; i < 4; i++)
         chk("t4_b2b", i, 32'(acc[i] - acc[0]), 32'(i));
      do_read(32'h8, rd, lat);
      chk("t4_rdata", 0, rd, 32'h0A0B0C02);

      // Throttle of 3 cycles after writes and after the read response.
      select(1);
      do_write(32'h10, 32'hFEEDFACE, 4'hF);
      count_ready_low(cnt);
      chk("t4_stall_wr", 1, 32'(cnt), 32'd3);
      do_read(32'h10, rd, lat);
      chk("t4_rdata_s", 1, rd, 32'hFEEDFACE);
      chk("t4_lat4",    1, lat, 32'd4);
      count_ready_low(cnt);
      chk("t4_stall_rd", 1, 32'(cnt), 32'd3);

      // Latency sweep.
      select(2);
      do_write(32'h20, 32'hA5A55A5A, 4'hF);
      do_read(32'h20, rd, lat);
      chk("t5_rdata1", 2, rd, 32'hA5A55A5A);
      chk("t5_lat1",   2, lat, 32'd1);
      select(3);
      do_write(32'h24, 32'h0F1E2D3C, 4'hF);
      do_read(32'h24, rd, lat);
      chk("t5_rdata8", 3, rd, 32'h0F1E2D3C);
      chk("t5_lat8",   3, lat, 32'd8);

      // Reset during the read wait (RD_LAT=4): no rvalid afterwards.
      select(1);
      begin
         int k;
         drive_req(32'h10, 32'h0, 4'h0, k);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (d_rvalid[1]) cnt++;
      end
      chk("t1_no_rvalid", 1, 32'(cnt), 32'd0);
      @(posedge clk);
      #1;

      // Range check / aliasing.
      select(0);
      do_write(32'h0, 32'hCAFEF00D, 4'hF);
      do_write(32'h00004000, 32'h00000055, 4'hF);
      @(negedge clk);
`ifdef BE_MEM_RANGE_CHECK_EN
      chk("t6_err", 0, {31'h0, d_err[0]}, 32'h1);
      @(posedge clk);
      #1;
      do_read(32'h0, rd, lat);
      chk("t6_word0", 0, rd, 32'hCAFEF00D);
      do_read(32'h00004000, rd, lat);
      chk("t6_oor_rd", 0, rd, 32'hDEADBEEF);
`else
      chk("t6_err", 0, {31'h0, d_err[0]}, 32'h0);
      @(posedge clk);
      #1;
      do_read(32'h0, rd, lat);
      chk("t6_word0", 0, rd, 32'h00000055);
      do_read(32'h00004000, rd, lat);
      chk("t6_alias_rd", 0, rd, 32'h00000055);
`endif
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/iob_be_mem_responder.md
Name: iob_be_mem_responder

Overview:
- Memory-side responder for the cache back-end native interface (valid/addr/wdata/wstrb/ready/rvalid/rdata).
- Answers the requests the cache issues on its be_* port.
- Word-organised RAM with programmable read latency and programmable post-access ready throttling.
- Used as the simulation and FPGA backing store behind the cache, and as a stress source for back-end stall handling.

Parameters:
- ADDR_W, 32: byte-address width of be_addr_i.
- DATA_W, 32: data width; must be 32. NB = DATA_W/8 = 4 strobe bits.
- MEM_ADDR_W, 12: log2 of RAM depth in words (4096 words).
- RD_LAT, 2: accept-to-rvalid latency in cycles; legal range 1..8.
- STALL_CYCLES, 0: cycles ready_o is held low after every completed access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- be_valid_i  in  1  request valid.
- be_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- be_wdata_i  in  DATA_W  write data.
- be_wstrb_i  in  NB  byte strobes; 0 = read, nonzero = write.
- be_ready_o  out  1  request accept; a request is accepted on an edge where be_valid_i && be_ready_o.
- be_rvalid_o  out  1  one-cycle read-data-valid pulse.
- be_rdata_o  out  DATA_W  read data, valid only while be_rvalid_o=1, otherwise 0.
- err_o  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- **Reset** (reset_n low, asynchronous):
  - state = IDLE; latency and stall counters = 0.
  - be_ready_o=1, be_rvalid_o=0, be_rdata_o=0, err_o=0.
  - RAM contents are not cleared.
- **Word index:** widx = be_addr_i[MEM_ADDR_W+1:2].
- **be_ready_o** = (state==IDLE), decoded from registered state only; it never depends combinationally on be_valid_i.
- **State IDLE:**
  - Read accepted: latch widx and load lat_cnt = RD_LAT-1.
    - If RD_LAT==1, go to RESP; otherwise go to RD_WAIT.
  - Write accepted: at the accepting edge, RAM[widx] byte b <= be_wdata_i byte b for each b with be_wstrb_i[b]=1; other bytes are unchanged.
    - Next state is STALL if STALL_CYCLES>0, else IDLE.
    - With STALL_CYCLES=0, back-to-back writes are accepted every cycle.
  - Writes never produce be_rvalid_o.
- **State RD_WAIT:**
  - lat_cnt decrements each cycle; go to RESP when lat_cnt==1.
  - be_ready_o=0; be_valid_i is ignored.
- **State RESP:** be_rvalid_o=1 and be_rdata_o=RAM[latched widx] for exactly one cycle.
  - Next state is STALL if STALL_CYCLES>0, else IDLE.
- **Read timing:** the accepting edge is edge k; be_rvalid_o is high in the cycle after edge k+RD_LAT-1.
  - RD_LAT=1: rvalid is high in the cycle immediately after acceptance.
- **State STALL:** stall_cnt counts up from 0; return to IDLE when stall_cnt==STALL_CYCLES-1.
- **Read-after-write:** a read of a word written by any earlier accepted write returns the new data; no forwarding hazard exists because writes commit at acceptance.
- **Request holding:** the master holds be_valid_i/addr/wdata/wstrb stable until accepted. The responder samples them only on the accepting edge.
- **One outstanding read.** A new request is never accepted in the RESP cycle; the earliest next acceptance is the cycle after RESP when STALL_CYCLES=0.
- **Reset mid-operation:** an in-flight read is discarded with no rvalid; a write already accepted stays committed.
- **Address aliasing:** without the optional feature, address bits above MEM_ADDR_W+1 are ignored (aliasing).

Optional Feature:
- Macro: BE_MEM_RANGE_CHECK_EN.
- **Defined:** an accepted request with be_addr_i[ADDR_W-1:MEM_ADDR_W+2] != 0 is out of range.
  - Out-of-range write: dropped, RAM unchanged.
  - Out-of-range read: completes with normal timing and returns 32'hDEADBEEF.
  - err_o sets on the accepting edge and clears only on reset.
- **Undefined:** no range check; addresses alias; err_o is tied to 0.

Test Plan:
1. Reset: reset_n=0 mid-idle, release -> ready=1, rvalid=0, rdata=0, err_o=0. Assert reset during RD_WAIT (RD_LAT=4) -> no rvalid pulse after release.
2. Write then read, RD_LAT=2, STALL_CYCLES=0:
   - Write addr 0x40 data 0x12345678 wstrb 4'hF, then read 0x40.
   - Expect rvalid exactly 2 cycles after read acceptance, rdata=0x12345678, ready=0 during the wait.
3. Byte strobes: word at 0x80 = 0xAABBCCDD, write wdata 0x11223344 wstrb 4'b0101 -> read returns 0xAA22CC44.
4. Throughput/stall:
   - STALL_CYCLES=0: 4 back-to-back writes to 0x0, 0x4, 0x8, 0xC accepted on 4 consecutive edges.
   - STALL_CYCLES=3: ready low exactly 3 cycles after each write and after each RESP.
5. Latency sweep: RD_LAT=1 and RD_LAT=8 reads of a known word -> rvalid after 1 and 8 cycles respectively. Each rvalid is a single-cycle pulse and rdata=0 outside it.
6. With BE_MEM_RANGE_CHECK_EN, MEM_ADDR_W=12:
   - Write 0x00004000 data 0x55 -> err_o=1 and word 0 unchanged.
   - Read 0x00004000 -> rdata=0xDEADBEEF.
   - Without the macro: the same write lands in word 0 and err_o stays 0.
